// File: rtl/icepic_lib_pkg.sv
// icepic_lib_pkg: shared iCEPIC types for program-flow sequencing (rev 1.0).
`default_nettype none

package icepic_lib_pkg;

  localparam int STACK_DEPTH_DEFAULT = 8;
  localparam int ADDR_W_DEFAULT      = 12;

  typedef enum logic [2:0] {
    PC_OP_NEXT      = 3'd0,
    PC_OP_GOTO      = 3'd1,
    PC_OP_CALL      = 3'd2,
    PC_OP_RETURN    = 3'd3,
    PC_OP_PCL_WRITE = 3'd4,
    PC_OP_SKIP      = 3'd5
  } pc_op_t;

  // PC_UPDATE_HOLD has no arm in pc's case statement, so pc keeps its value.
  typedef enum logic [2:0] {
    PC_UPDATE_INC     = 3'd0,
    PC_UPDATE_JUMP    = 3'd1,
    PC_UPDATE_RET     = 3'd2,
    PC_UPDATE_PCL_MOD = 3'd3,
    PC_UPDATE_HOLD    = 3'd4
  } pc_update_sel_t;

endpackage

`default_nettype wire

// File: rtl/pc_seq_if.sv
// pc_seq_if: decoder/pc-side bus of the sequencer; flag signals exist only
// with STACK_OVF_FLAG_EN (rev 1.0).
`default_nettype none

interface pc_seq_if
  import icepic_lib_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) ();

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic               op_valid_in;
  pc_op_t             op_in;
  logic               skip_cond_in;
  logic               stall_in;
  logic [ADDR_W-1:0]  pc_in;
  pc_update_sel_t     pc_sel_out;
  logic [ADDR_W-1:0]  stack_addr_out;
  logic               flush_out;
  logic [DEPTH_W-1:0] stack_depth_out;
`ifdef STACK_OVF_FLAG_EN
  logic               stack_ovf_out;
  logic               stack_unf_out;
`endif

  modport master (
    output op_valid_in, op_in, skip_cond_in, stall_in, pc_in,
    input  pc_sel_out, stack_addr_out, flush_out, stack_depth_out
`ifdef STACK_OVF_FLAG_EN
    , input stack_ovf_out, stack_unf_out
`endif
  );

  modport slave (
    input  op_valid_in, op_in, skip_cond_in, stall_in, pc_in,
    output pc_sel_out, stack_addr_out, flush_out, stack_depth_out
`ifdef STACK_OVF_FLAG_EN
    , output stack_ovf_out, stack_unf_out
`endif
  );

endinterface

`default_nettype wire

// File: rtl/call_stack.sv
// call_stack: circular hardware return stack with saturating depth; sticky
// overflow/underflow flags with STACK_OVF_FLAG_EN (rev 1.0).
`default_nettype none

module call_stack
  import icepic_lib_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               push_in,
  input  logic               pop_in,
  input  logic [ADDR_W-1:0]  push_data_in,
  output logic [ADDR_W-1:0]  top_out,
  output logic [DEPTH_W-1:0] depth_out
`ifdef STACK_OVF_FLAG_EN
  , output logic             ovf_out
  , output logic             unf_out
`endif
);

  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  entry_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  entry_d [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q, sp_d, sp_m1;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  // Pointer wraps freely; only the depth counter saturates.
  assign sp_m1     = sp_q - SP_W'(1);
  assign top_out   = entry_q[sp_m1];
  assign depth_out = depth_q;

  always_comb begin
    entry_d = entry_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    if (push_in) begin
      entry_d[sp_q] = push_data_in;
      sp_d          = sp_q + SP_W'(1);
      if (depth_q != DEPTH_FULL) depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_in) begin
      sp_d = sp_m1;
      if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      entry_q <= '{default: '0};
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      entry_q <= entry_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

`ifdef STACK_OVF_FLAG_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (push_in && (depth_q == DEPTH_FULL));
    unf_d = unf_q | (pop_in && (depth_q == '0));
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_out = ovf_q;
  assign unf_out = unf_q;
`endif

endmodule

`default_nettype wire

// File: rtl/pc_seq.sv
// pc_seq: decodes instruction flow class into the pc select, owns the return
// stack and flushes after two-cycle instructions; STACK_OVF_FLAG_EN adds flags (rev 1.0).
`default_nettype none

module pc_seq
  import icepic_lib_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT
) (
  input  logic     clk_in,
  input  logic     reset_n_in,
  pc_seq_if.slave  bus
);

  localparam logic [0:0] S_EXEC  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]        state_q, state_d;
  pc_update_sel_t    sel;
  logic              push, pop;
  logic [ADDR_W-1:0] top;

  always_comb begin
    state_d = state_q;
    sel     = PC_UPDATE_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    if (!bus.stall_in) begin
      case (state_q)
        S_FLUSH: begin
          sel     = PC_UPDATE_INC;
          state_d = S_EXEC;
        end
        default: begin
          if (bus.op_valid_in) begin
            case (bus.op_in)
              PC_OP_NEXT: sel = PC_UPDATE_INC;
              PC_OP_GOTO: begin
                sel     = PC_UPDATE_JUMP;
                state_d = S_FLUSH;
              end
              PC_OP_CALL: begin
                sel     = PC_UPDATE_JUMP;
                push    = 1'b1;
                state_d = S_FLUSH;
              end
              PC_OP_RETURN: begin
                sel     = PC_UPDATE_RET;
                pop     = 1'b1;
                state_d = S_FLUSH;
              end
              PC_OP_PCL_WRITE: begin
                sel     = PC_UPDATE_PCL_MOD;
                state_d = S_FLUSH;
              end
              PC_OP_SKIP: begin
                sel = PC_UPDATE_INC;
                if (bus.skip_cond_in) state_d = S_FLUSH;
              end
              default: sel = PC_UPDATE_HOLD;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= S_EXEC;
    else             state_q <= state_d;
  end

  // Select depends on live inputs, so it is forced to HOLD while reset is held.
  assign bus.pc_sel_out     = reset_n_in ? sel : PC_UPDATE_HOLD;
  assign bus.flush_out      = reset_n_in && (state_q == S_FLUSH);
  assign bus.stack_addr_out = reset_n_in ? top : '0;

  call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_stack (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .push_in      (push),
    .pop_in       (pop),
    .push_data_in (bus.pc_in),
    .top_out      (top),
    .depth_out    (bus.stack_depth_out)
`ifdef STACK_OVF_FLAG_EN
    , .ovf_out    (bus.stack_ovf_out)
    , .unf_out    (bus.stack_unf_out)
`endif
  );

endmodule

`default_nettype wire
